// File: rtl/rs232_command_parser_if.sv
// Signal bundle between the command parser and its neighbours: the UART
// receiver (rx_*), the local register bus (reg_*), the transmit FIFO (tx_fifo_*)
// and the status flags. The parser is the master of the register bus and the
// FIFO; the slave modport is the environment side (receiver, registers, FIFO).
interface rs232_command_parser_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_write;
  logic       reg_read;
  logic [7:0] reg_rdata;
  logic [7:0] tx_fifo_data;
  logic       tx_fifo_write;
  logic       tx_fifo_full;
  logic       busy;
  logic       frame_error;
  logic       overrun;

  modport master (
    input  rx_byte,
    input  rx_valid,
    input  reg_rdata,
    input  tx_fifo_full,
    output reg_addr,
    output reg_wdata,
    output reg_write,
    output reg_read,
    output tx_fifo_data,
    output tx_fifo_write,
    output busy,
    output frame_error,
    output overrun
  );

  modport slave (
    output rx_byte,
    output rx_valid,
    output reg_rdata,
    output tx_fifo_full,
    input  reg_addr,
    input  reg_wdata,
    input  reg_write,
    input  reg_read,
    input  tx_fifo_data,
    input  tx_fifo_write,
    input  busy,
    input  frame_error,
    input  overrun
  );
endinterface

// File: rtl/rs232_command_parser.sv
// Byte-level command parser: assembles 5-byte frames (A5 CMD ADDR DATA CHK),
// performs one register read or write, and pushes a 4-byte response
// (5A STATUS RDATA RCHK) into the transmit FIFO.
//
// state   | meaning
// --------+-----------------------------------------------------------
// HUNT    | idle, waiting for the 0xA5 sync byte
// CMD     | waiting for the command byte
// ADDR    | waiting for the address byte
// DATA    | waiting for the data byte
// CHK     | waiting for the checksum byte
// EXEC    | checksum/command decode, issue the bus strobe
// RDWAIT  | capture read data returned one cycle after reg_read
// RESP    | push response bytes 0..3, stalling while the FIFO is full
module rs232_command_parser #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TIMEOUT_WIDTH  = 13
) (
  input logic                  clock,
  input logic                  reset,
  rs232_command_parser_if.master bus
);

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam logic [7:0] RESP_BYTE  = 8'h5A;
  localparam logic [7:0] CMD_WRITE  = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;
  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_BAD_CHK = 8'h01;
  localparam logic [7:0] ST_BAD_CMD = 8'h02;

  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_HUNT,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_CHK,
    S_EXEC,
    S_RDWAIT,
    S_RESP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [7:0] cmd_q;
  logic [7:0] addr_q;
  logic [7:0] data_q;
  logic [7:0] chk_q;
  logic [7:0] status_q;
  logic [7:0] rdata_q;
  logic [1:0] idx_q;
  logic [7:0] reg_addr_q;
  logic [7:0] reg_wdata_q;
  logic       overrun_q;
  logic [TIMEOUT_WIDTH-1:0] timer_q;

  logic [7:0] frame_sum;
  logic       sum_ok;
  logic       is_write;
  logic       is_read;
  logic       in_frame;
  logic       timeout_hit;
  logic       push;
  logic       drop_byte;

  // 8-bit checksum of the captured frame body; carries fall off naturally.
  assign frame_sum = cmd_q + addr_q + data_q;
  assign sum_ok    = (frame_sum == chk_q);
  assign is_write  = (cmd_q == CMD_WRITE);
  assign is_read   = (cmd_q == CMD_READ);

  assign in_frame  = (state_q == S_CMD) || (state_q == S_ADDR) ||
                     (state_q == S_DATA) || (state_q == S_CHK);

  // A byte arriving on the expiry cycle wins over the abort.
  assign timeout_hit = in_frame && (timer_q == TIMEOUT_LIMIT) && !bus.rx_valid;

  assign push      = (state_q == S_RESP) && !bus.tx_fifo_full;

  assign drop_byte = bus.rx_valid &&
                     ((state_q == S_EXEC) || (state_q == S_RDWAIT) || (state_q == S_RESP));

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HUNT: begin
        if (bus.rx_valid && (bus.rx_byte == SYNC_BYTE)) begin
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (bus.rx_valid) begin
          state_d = S_ADDR;
        end else if (timeout_hit) begin
          state_d = S_HUNT;
        end
      end
      S_ADDR: begin
        if (bus.rx_valid) begin
          state_d = S_DATA;
        end else if (timeout_hit) begin
          state_d = S_HUNT;
        end
      end
      S_DATA: begin
        if (bus.rx_valid) begin
          state_d = S_CHK;
        end else if (timeout_hit) begin
          state_d = S_HUNT;
        end
      end
      S_CHK: begin
        if (bus.rx_valid) begin
          state_d = S_EXEC;
        end else if (timeout_hit) begin
          state_d = S_HUNT;
        end
      end
      S_EXEC: begin
        if (sum_ok && is_read) begin
          state_d = S_RDWAIT;
        end else begin
          state_d = S_RESP;
        end
      end
      S_RDWAIT: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (push && (idx_q == 2'd3)) begin
          state_d = S_HUNT;
        end
      end
      default: begin
        state_d = S_HUNT;
      end
    endcase
  end

  // Output decode: strobes, FIFO push and response byte selection.
  always_comb begin
    bus.busy          = (state_q != S_HUNT);
    bus.reg_write     = (state_q == S_EXEC) && sum_ok && is_write;
    bus.reg_read      = (state_q == S_EXEC) && sum_ok && is_read;
    bus.tx_fifo_write = push;
    bus.frame_error   = timeout_hit;
    bus.tx_fifo_data  = 8'h00;
    if (state_q == S_RESP) begin
      case (idx_q)
        2'd0:    bus.tx_fifo_data = RESP_BYTE;
        2'd1:    bus.tx_fifo_data = status_q;
        2'd2:    bus.tx_fifo_data = rdata_q;
        default: bus.tx_fifo_data = status_q + rdata_q;
      endcase
    end
  end

  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.overrun   = overrun_q;

  // Frame byte capture and inter-byte timeout counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      cmd_q   <= 8'h00;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
      chk_q   <= 8'h00;
      timer_q <= '0;
    end else begin
      if (bus.rx_valid) begin
        case (state_q)
          S_CMD:   cmd_q  <= bus.rx_byte;
          S_ADDR:  addr_q <= bus.rx_byte;
          S_DATA:  data_q <= bus.rx_byte;
          S_CHK:   chk_q  <= bus.rx_byte;
          default: ;
        endcase
      end
      // HUNT keeps the counter at zero, so CMD is always entered fresh.
      if (!in_frame || bus.rx_valid) begin
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + TIMEOUT_WIDTH'(1);
      end
    end
  end

  // Bus address/data holding registers. They are loaded on the CHK byte edge
  // so they are already stable during the EXEC strobe cycle, and only for
  // frames that will actually strobe, so they hold between strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
    end else if ((state_q == S_CHK) && bus.rx_valid && (bus.rx_byte == frame_sum)) begin
      if (is_write) begin
        reg_addr_q  <= addr_q;
        reg_wdata_q <= data_q;
      end else if (is_read) begin
        reg_addr_q  <= addr_q;
      end
    end
  end

  // Response status/data, byte index and sticky overrun flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      status_q  <= 8'h00;
      rdata_q   <= 8'h00;
      idx_q     <= 2'd0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        S_EXEC: begin
          idx_q <= 2'd0;
          if (!sum_ok) begin
            status_q <= ST_BAD_CHK;
            rdata_q  <= 8'h00;
          end else if (is_write) begin
            status_q <= ST_OK;
            rdata_q  <= data_q;
          end else if (is_read) begin
            status_q <= ST_OK;
            rdata_q  <= 8'h00;
          end else begin
            status_q <= ST_BAD_CMD;
            rdata_q  <= 8'h00;
          end
        end
        S_RDWAIT: begin
          rdata_q <= bus.reg_rdata;
        end
        S_RESP: begin
          if (push) begin
            idx_q <= idx_q + 2'd1;
          end
        end
        default: ;
      endcase
      if (drop_byte) begin
        overrun_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rs232_command_parser.sv
// Directed testbench for rs232_command_parser. Inputs change 1 ns after the
// rising edge; the monitor samples outputs on the falling edge.
module tb_rs232_command_parser;

  localparam int TO_CYCLES = 20;
  localparam int TO_WIDTH  = 5;

  logic clock;
  logic reset;

  rs232_command_parser_if bus_if ();

  rs232_command_parser #(
    .TIMEOUT_CYCLES (TO_CYCLES),
    .TIMEOUT_WIDTH  (TO_WIDTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] push_q[$];
  int n_wr       = 0;
  int n_rd       = 0;
  int n_ferr     = 0;
  int n_bad_push = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: record FIFO pushes and count strobes on the falling edge.
  always @(negedge clock) begin
    if (bus_if.tx_fifo_write) push_q.push_back(bus_if.tx_fifo_data);
    if (bus_if.reg_write) n_wr <= n_wr + 1;
    if (bus_if.reg_read) n_rd <= n_rd + 1;
    if (bus_if.frame_error) n_ferr <= n_ferr + 1;
    if (bus_if.tx_fifo_write && bus_if.tx_fifo_full) n_bad_push <= n_bad_push + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus_if.rx_byte  = b;
    bus_if.rx_valid = 1'b1;
    next_cycle();
    bus_if.rx_valid = 1'b0;
    bus_if.rx_byte  = 8'h00;
    #1;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                            input logic [7:0] d, input logic [7:0] k);
    send_byte(8'hA5);
    send_byte(c);
    send_byte(a);
    send_byte(d);
    send_byte(k);
  endtask

  // Wait for busy to drop; an expired budget shows up as a failed check.
  task automatic wait_idle(input string tag, output int n);
    n = 0;
    while (bus_if.busy && n < 100) begin
      next_cycle();
      n++;
    end
    check(tag, bus_if.busy, 0);
  endtask

  function automatic logic [31:0] pushed(input int i);
    if (i < push_q.size()) return {24'h0, push_q[i]};
    return 32'hxxxx_xxxx;
  endfunction

  task automatic check_resp(input string tag, input int base, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    check({tag, "_count"}, push_q.size() - base, 4);
    check({tag, "_b0"}, pushed(base), b0);
    check({tag, "_b1"}, pushed(base + 1), b1);
    check({tag, "_b2"}, pushed(base + 2), b2);
    check({tag, "_b3"}, pushed(base + 3), b3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int b_wr;
    int b_rd;
    int b_fe;
    int n;
    int s2;

    reset                = 1'b1;
    bus_if.rx_byte       = 8'h00;
    bus_if.rx_valid      = 1'b0;
    bus_if.reg_rdata     = 8'h00;
    bus_if.tx_fifo_full  = 1'b0;
    repeat (3) next_cycle();

    // Reset state
    check("rst_busy", bus_if.busy, 0);
    check("rst_reg_write", bus_if.reg_write, 0);
    check("rst_reg_read", bus_if.reg_read, 0);
    check("rst_tx_write", bus_if.tx_fifo_write, 0);
    check("rst_tx_data", bus_if.tx_fifo_data, 8'h00);
    check("rst_reg_addr", bus_if.reg_addr, 8'h00);
    check("rst_reg_wdata", bus_if.reg_wdata, 8'h00);
    check("rst_ferr", bus_if.frame_error, 0);
    check("rst_overrun", bus_if.overrun, 0);
    reset = 1'b0;
    next_cycle();

    // Write A5 01 10 3C 4D
    base = push_q.size();
    b_wr = n_wr;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10); send_byte(8'h3C);
    send_byte(8'h4D);
    check("wr_strobe", bus_if.reg_write, 1);
    check("wr_addr", bus_if.reg_addr, 8'h10);
    check("wr_wdata", bus_if.reg_wdata, 8'h3C);
    check("wr_no_push_exec", bus_if.tx_fifo_write, 0);
    next_cycle();
    check("wr_first_push", bus_if.tx_fifo_write, 1);
    check("wr_first_data", bus_if.tx_fifo_data, 8'h5A);
    wait_idle("wr_idle", n);
    check("wr_busy_fall", n, 4);
    check_resp("wr_resp", base, 8'h5A, 8'h00, 8'h3C, 8'h3C);
    check("wr_count", n_wr - b_wr, 1);
    check("wr_addr_hold", bus_if.reg_addr, 8'h10);

    // Read A5 02 22 00 24, reg_rdata valid only in the RDWAIT cycle
    base = push_q.size();
    b_rd = n_rd;
    b_wr = n_wr;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h22); send_byte(8'h00);
    send_byte(8'h24);
    check("rd_strobe", bus_if.reg_read, 1);
    check("rd_no_write", bus_if.reg_write, 0);
    check("rd_addr", bus_if.reg_addr, 8'h22);
    check("rd_wdata_hold", bus_if.reg_wdata, 8'h3C);
    bus_if.reg_rdata = 8'h7E;
    next_cycle();
    check("rd_no_push_wait", bus_if.tx_fifo_write, 0);
    next_cycle();
    bus_if.reg_rdata = 8'hC3;
    check("rd_first_push", bus_if.tx_fifo_write, 1);
    wait_idle("rd_idle", n);
    check_resp("rd_resp", base, 8'h5A, 8'h00, 8'h7E, 8'h7E);
    check("rd_count", n_rd - b_rd, 1);
    check("rd_wr_count", n_wr - b_wr, 0);

    // Bad checksum
    base = push_q.size();
    b_wr = n_wr;
    send_frame(8'h01, 8'h10, 8'h3C, 8'h00);
    check("badchk_no_strobe", bus_if.reg_write, 0);
    wait_idle("badchk_idle", n);
    check_resp("badchk_resp", base, 8'h5A, 8'h01, 8'h00, 8'h01);
    check("badchk_wr_count", n_wr - b_wr, 0);

    // Unknown command
    base = push_q.size();
    b_wr = n_wr;
    b_rd = n_rd;
    send_frame(8'h07, 8'h00, 8'h00, 8'h07);
    wait_idle("badcmd_idle", n);
    check_resp("badcmd_resp", base, 8'h5A, 8'h02, 8'h00, 8'h02);
    check("badcmd_strobes", (n_wr - b_wr) + (n_rd - b_rd), 0);

    // A5 inside the frame is data; checksum carry discarded (01+A5+A5=14B)
    base = push_q.size();
    send_frame(8'h01, 8'hA5, 8'hA5, 8'h4B);
    check("a5data_addr", bus_if.reg_addr, 8'hA5);
    check("a5data_strobe", bus_if.reg_write, 1);
    wait_idle("a5data_idle", n);
    check_resp("a5data_resp", base, 8'h5A, 8'h00, 8'hA5, 8'hA5);

    // Timeout after A5 01 then silence
    b_fe = n_ferr;
    send_byte(8'hA5);
    send_byte(8'h01);
    n = 0;
    while (!bus_if.frame_error && n < 60) begin
      next_cycle();
      n++;
    end
    check("to_cycles", n, TO_CYCLES);
    check("to_pulse", bus_if.frame_error, 1);
    next_cycle();
    check("to_pulse_end", bus_if.frame_error, 0);
    check("to_hunt", bus_if.busy, 0);
    check("to_count", n_ferr - b_fe, 1);

    // Following valid frame executes normally
    base = push_q.size();
    send_frame(8'h01, 8'h55, 8'h66, 8'hBC);
    check("post_to_strobe", bus_if.reg_write, 1);
    wait_idle("post_to_idle", n);
    check_resp("post_to_resp", base, 8'h5A, 8'h00, 8'h66, 8'h66);

    // Byte on the expiry cycle is accepted
    base = push_q.size();
    b_fe = n_ferr;
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (TO_CYCLES) next_cycle();
    check("exp_would_abort", bus_if.frame_error, 1);
    bus_if.rx_byte  = 8'h30;
    bus_if.rx_valid = 1'b1;
    #1;
    check("exp_byte_wins", bus_if.frame_error, 0);
    next_cycle();
    bus_if.rx_valid = 1'b0;
    #1;
    check("exp_still_busy", bus_if.busy, 1);
    send_byte(8'h12);
    send_byte(8'h43);
    check("exp_strobe", bus_if.reg_write, 1);
    wait_idle("exp_idle", n);
    check_resp("exp_resp", base, 8'h5A, 8'h00, 8'h12, 8'h12);
    check("exp_no_ferr", n_ferr - b_fe, 0);

    // Backpressure mid-response with an injected byte
    check("ovr_clear", bus_if.overrun, 0);
    base = push_q.size();
    send_frame(8'h01, 8'h40, 8'h99, 8'hDA);
    next_cycle();
    next_cycle();
    bus_if.tx_fifo_full = 1'b1;
    #1;
    check("bp_no_push", bus_if.tx_fifo_write, 0);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      bus_if.rx_byte  = 8'hA5;
      bus_if.rx_valid = (i == 1);
      #1;
      check("bp_stall_push", bus_if.tx_fifo_write, 0);
      check("bp_stall_busy", bus_if.busy, 1);
    end
    bus_if.rx_valid = 1'b0;
    check("bp_partial", push_q.size() - base, 1);
    check("ovr_set", bus_if.overrun, 1);
    bus_if.tx_fifo_full = 1'b0;
    wait_idle("bp_idle", n);
    check_resp("bp_resp", base, 8'h5A, 8'h00, 8'h99, 8'h99);
    check("bp_full_push", n_bad_push, 0);
    next_cycle();
    check("ovr_no_resync", bus_if.busy, 0);

    // Overrun stays set across a later frame
    send_frame(8'h07, 8'h00, 8'h00, 8'h07);
    wait_idle("ovr_idle", n);
    check("ovr_sticky", bus_if.overrun, 1);

    // Reset during response index 2
    base = push_q.size();
    send_frame(8'h01, 8'h10, 8'h3C, 8'h4D);
    next_cycle();
    next_cycle();
    next_cycle();
    reset = 1'b1;
    next_cycle();
    check("rst2_busy", bus_if.busy, 0);
    check("rst2_tx_write", bus_if.tx_fifo_write, 0);
    check("rst2_tx_data", bus_if.tx_fifo_data, 8'h00);
    check("rst2_reg_addr", bus_if.reg_addr, 8'h00);
    check("rst2_reg_wdata", bus_if.reg_wdata, 8'h00);
    check("rst2_overrun", bus_if.overrun, 0);
    check("rst2_b0", pushed(base), 8'h5A);
    check("rst2_b1", pushed(base + 1), 8'h00);
    reset = 1'b0;
    s2 = push_q.size();
    repeat (6) next_cycle();
    check("rst2_no_more_push", push_q.size(), s2);

    // Garbage before sync is ignored
    send_byte(8'h33);
    send_byte(8'h44);
    check("garbage_hunt", bus_if.busy, 0);
    base = push_q.size();
    send_frame(8'h01, 8'h10, 8'h3C, 8'h4D);
    wait_idle("garbage_idle", n);
    check_resp("garbage_resp", base, 8'h5A, 8'h00, 8'h3C, 8'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rs232_command_parser.md
# rs232_command_parser

Byte-level command parser sitting directly downstream of the UART receiver and upstream of its transmit buffer. Consumes one received byte per `rx_valid` pulse and assembles fixed 5-byte command frames. Executes single-register reads/writes on the local register bus. Pushes a 4-byte response frame into the transmit FIFO that feeds the UART transmitter.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 4096: idle cycles allowed between bytes inside a frame before abort.
- `TIMEOUT_WIDTH`, default 13: width of the inter-byte timeout counter; must hold `TIMEOUT_CYCLES`.

Ports:
- `clock`  in  1  single clock, same domain as `rx_byte`/`rx_valid`.
- `reset`  in  1  synchronous, active-high.
- `rx_byte`  in  8  received byte, valid when `rx_valid`=1.
- `rx_valid`  in  1  one-cycle pulse per received byte.
- `reg_addr`  out  8  register bus address.
- `reg_wdata`  out  8  register bus write data.
- `reg_write`  out  1  one-cycle write strobe.
- `reg_read`  out  1  one-cycle read strobe.
- `reg_rdata`  in  8  read data, valid exactly 1 cycle after `reg_read`.
- `tx_fifo_data`  out  8  response byte to transmit FIFO.
- `tx_fifo_write`  out  1  FIFO push, only when `tx_fifo_full`=0.
- `tx_fifo_full`  in  1  FIFO full.
- `busy`  out  1  high in every state except HUNT.
- `frame_error`  out  1  one-cycle pulse on timeout abort.
- `overrun`  out  1  sticky; set when a byte is dropped in EXEC/RDWAIT/RESP; cleared only by reset.

## Operation
- Command frame: `0xA5`, CMD, ADDR, DATA, CHK.
  - CHK = (CMD+ADDR+DATA) mod 256.
  - CMD `0x01` = write, `0x02` = read; DATA is ignored for reads but included in CHK.
- Response frame: `0x5A`, STATUS, RDATA, RCHK.
  - RCHK = (STATUS+RDATA) mod 256.
  - STATUS: `0x00` ok, `0x01` bad checksum, `0x02` unknown CMD.
  - RDATA: read value for reads, echoed DATA for writes, `0x00` on error.
- States:
  - HUNT: wait for `rx_valid` with `rx_byte`=`0xA5`; other bytes discarded.
  - CMD, ADDR, DATA, CHK: each `rx_valid` latches the byte and advances.
  - CHK: on byte, go to EXEC.
  - EXEC:
    - Checksum mismatch → STATUS `0x01`, no bus access. Checksum is checked before CMD.
    - Write → `reg_write`=1 with `reg_addr`/`reg_wdata` for one cycle, STATUS `0x00`.
    - Read → `reg_read`=1, go to RDWAIT.
    - Unknown CMD → STATUS `0x02`, no bus access.
    - Non-read paths go to RESP.
  - RDWAIT: capture `reg_rdata`, go to RESP.
  - RESP: index 0..3; each cycle with `tx_fifo_full`=0 push one byte and increment the index; a full FIFO stalls with no push. After index 3 is pushed, return to HUNT.
- Timeout (CMD..CHK only):
  - Counter cleared on every `rx_valid` and on entry to CMD.
  - When the counter reaches `TIMEOUT_CYCLES` without a byte: pulse `frame_error` and go to HUNT.
  - `rx_valid` in the same cycle as expiry: the byte wins and no abort occurs.
- `rx_valid` in EXEC, RDWAIT or RESP: byte dropped, `overrun` set. No re-sync mid-response.
- `0xA5` appearing as CMD/ADDR/DATA/CHK is treated as data, not as a new sync.

## Timing
- Reset values:
  - All outputs 0; `reg_addr`, `reg_wdata`, `tx_fifo_data` = `0x00`.
  - State HUNT, timeout counter 0, `overrun` 0.
- Reset mid-frame or mid-response: immediate return to HUNT next cycle; partially sent response is abandoned.
- CHK byte at cycle N → EXEC at N+1:
  - `reg_write` or `reg_read` asserted at N+1.
  - Write/error: first `tx_fifo_write` at N+2.
  - Read: `reg_rdata` sampled at N+2, first push at N+3.
- Unstalled response: 4 consecutive `tx_fifo_write` cycles; `busy` falls the cycle after the last push.
- `reg_addr`/`reg_wdata` hold their last values between strobes.
- Checksum arithmetic is 8-bit, with carries discarded.

## Test plan
- Write: bytes A5 01 10 3C 4D → one `reg_write` with addr `0x10`, data `0x3C`; FIFO receives 5A 00 3C 3C.
- Read: A5 02 22 00 24 with `reg_rdata`=`0x7E` → one `reg_read` at addr `0x22`; FIFO receives 5A 00 7E 7E.
- Bad checksum: A5 01 10 3C 00 → no strobe; FIFO receives 5A 01 00 01. Unknown command: A5 07 00 00 07 → 5A 02 00 02.
- Timeout: A5 01 then silence for `TIMEOUT_CYCLES` → `frame_error` pulse, back in HUNT. A following valid frame executes normally. Byte arriving on the expiry cycle is accepted.
- Backpressure/overrun:
  - Hold `tx_fifo_full`=1 during RESP → no pushes, state held.
  - Release → remaining bytes pushed in order.
  - Inject an `rx_valid` during RESP → `overrun`=1, response unchanged.
- Reset asserted during RESP index 2 → all outputs 0 next cycle and no further pushes; garbage bytes before `0xA5` are ignored afterwards.
